// File: rtl/uart_pkg.sv
// Shared state encodings, bit-period derivation and parity helper for the UART.
package uart_pkg;

  localparam int PAR_MAX_W = 32;

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;

  function automatic int calc_bit_clks(input int clk_freq_mhz, input int baud_kbps);
    return (clk_freq_mhz * 1000) / baud_kbps;
  endfunction

  // Callers zero-extend narrower words; the extra zeros leave the XOR unchanged.
  function automatic logic calc_parity(input logic [PAR_MAX_W-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronizer, start-edge detect, mid-bit sampling; outputs load
// at the mid-stop sample, no backpressure (each frame overwrites the previous result).
module uart_rx
  import uart_pkg::*;
#(
  parameter int D_WIDTH    = 8,
  parameter bit PARITY_O_1 = 1'b0,
  parameter int BIT_CLKS   = 50
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx,
  output logic [D_WIDTH-1:0] data_out,
  output logic               error_flag
);

  localparam int CNT_W = $clog2(BIT_CLKS);
  localparam int IDX_W = (D_WIDTH > 1) ? $clog2(D_WIDTH) : 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_CLKS / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CLKS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(D_WIDTH - 1);

  rx_state_e          state;
  logic               rx_meta, rx_sync, rx_prev;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   idx;
  logic [D_WIDTH-1:0] word;
  logic               par_bit;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RX_IDLE;
      cnt        <= '0;
      idx        <= '0;
      word       <= '0;
      par_bit    <= 1'b0;
      data_out   <= '0;
      error_flag <= 1'b0;
    end else begin
      cnt <= (state == RX_IDLE || cnt == BIT_LAST) ? '0 : cnt + 1'b1;
      case (state)
        RX_IDLE: begin
          idx <= '0;
          if (rx_prev && !rx_sync) state <= RX_START;
        end
        RX_START: begin
          // Half a bit in: a line already back high was a glitch, not a start bit.
          if (cnt == HALF_LAST) begin
            cnt   <= '0;
            state <= rx_sync ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: begin
          if (cnt == BIT_LAST) begin
            word[idx] <= rx_sync;
            if (idx == IDX_LAST) state <= RX_PARITY;
            else                 idx   <= idx + 1'b1;
          end
        end
        RX_PARITY: begin
          if (cnt == BIT_LAST) begin
            par_bit <= rx_sync;
            state   <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (cnt == BIT_LAST) begin
            data_out   <= word;
            error_flag <= (par_bit != calc_parity(PAR_MAX_W'(word), PARITY_O_1)) | !rx_sync;
            state      <= RX_IDLE;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_transceiver.sv
// Full-duplex UART (start, D_WIDTH data LSB first, parity, stop). Tx falls one cycle after
// start is accepted; start is only sampled while idle or at the end of the stop bit.
module uart_transceiver
  import uart_pkg::*;
#(
  parameter int D_WIDTH      = 8,
  parameter bit PARITY_O_1   = 1'b0,
  parameter int CLK_FREQ_MHZ = 50,
  parameter int BAUD_KBPS    = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [D_WIDTH-1:0] data_in,
  input  logic               Rx,
  output logic [D_WIDTH-1:0] data_out,
  output logic               error_flag,
  output logic               Tx
);

  localparam int BIT_CLKS = calc_bit_clks(CLK_FREQ_MHZ, BAUD_KBPS);
  localparam int CNT_W    = $clog2(BIT_CLKS);
  localparam int IDX_W    = (D_WIDTH > 1) ? $clog2(D_WIDTH) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BIT_CLKS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(D_WIDTH - 1);

  tx_state_e          tx_state;
  logic [CNT_W-1:0]   tx_cnt;
  logic [IDX_W-1:0]   tx_idx;
  logic [D_WIDTH-1:0] tx_data;
  logic               bit_done;

  assign bit_done = (tx_cnt == BIT_LAST);

  // Tx is registered from the current state, so the line trails the FSM by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_data  <= '0;
      Tx       <= 1'b1;
    end else begin
      tx_cnt <= (tx_state == TX_IDLE || bit_done) ? '0 : tx_cnt + 1'b1;
      case (tx_state)
        TX_IDLE: begin
          Tx <= 1'b1;
          if (start) begin
            tx_data  <= data_in;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          Tx <= 1'b0;
          if (bit_done) begin
            tx_idx   <= '0;
            tx_state <= TX_DATA;
          end
        end
        TX_DATA: begin
          Tx <= tx_data[tx_idx];
          if (bit_done) begin
            if (tx_idx == IDX_LAST) tx_state <= TX_PARITY;
            else                    tx_idx   <= tx_idx + 1'b1;
          end
        end
        TX_PARITY: begin
          Tx <= calc_parity(PAR_MAX_W'(tx_data), PARITY_O_1);
          if (bit_done) tx_state <= TX_STOP;
        end
        TX_STOP: begin
          Tx <= 1'b1;
          if (bit_done) begin
            if (start) begin
              tx_data  <= data_in;
              tx_state <= TX_START;
            end else begin
              tx_state <= TX_IDLE;
            end
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  uart_rx #(
    .D_WIDTH   (D_WIDTH),
    .PARITY_O_1(PARITY_O_1),
    .BIT_CLKS  (BIT_CLKS)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx        (Rx),
    .data_out  (data_out),
    .error_flag(error_flag)
  );

endmodule

// File: tb/tb_uart_transceiver.sv
// Bench: A/B even-parity link, C odd-parity transmitter, injected line frames on A's Rx.
`timescale 1ns/1ps
module tb_uart_transceiver;

  localparam int DW = 8;
  localparam int BC = 50 * 1000 / 1000;
  localparam int FRAME_BITS = DW + 3;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic          rst;
  logic          a_start, b_start, c_start;
  logic [DW-1:0] a_din, b_din, c_din;
  logic          a_rx, b_rx, c_rx;
  logic          a_tx, b_tx, c_tx;
  logic [DW-1:0] a_dout, b_dout, c_dout;
  logic          a_err, b_err, c_err;
  logic          inj_sel, inj_line;

  assign a_rx = inj_sel ? inj_line : b_tx;
  assign b_rx = a_tx;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] exp_a_dout, exp_b_dout;
  logic          exp_a_err, exp_b_err;

  uart_transceiver #(.D_WIDTH(DW), .PARITY_O_1(1'b0), .CLK_FREQ_MHZ(50), .BAUD_KBPS(1000)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .data_in(a_din), .Rx(a_rx),
    .data_out(a_dout), .error_flag(a_err), .Tx(a_tx));

  uart_transceiver #(.D_WIDTH(DW), .PARITY_O_1(1'b0), .CLK_FREQ_MHZ(50), .BAUD_KBPS(1000)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .data_in(b_din), .Rx(b_rx),
    .data_out(b_dout), .error_flag(b_err), .Tx(b_tx));

  uart_transceiver #(.D_WIDTH(DW), .PARITY_O_1(1'b1), .CLK_FREQ_MHZ(50), .BAUD_KBPS(1000)) dut_c (
    .clk(clk), .rst(rst), .start(c_start), .data_in(c_din), .Rx(c_rx),
    .data_out(c_dout), .error_flag(c_err), .Tx(c_tx));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference frame: bit 0 first on the wire.
  function automatic logic [FRAME_BITS-1:0] make_frame(input logic [DW-1:0] d, input bit odd);
    logic [FRAME_BITS-1:0] f;
    int ones;
    ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < DW; i++) begin
      f[1+i] = d[i];
      ones += int'(d[i]);
    end
    f[DW+1] = ((ones % 2) == 1) != odd;
    f[DW+2] = 1'b1;
    return f;
  endfunction

  function automatic logic get_tx(input int sel);
    if (sel == 0) return a_tx;
    if (sel == 1) return b_tx;
    return c_tx;
  endfunction

  // Entered half a cycle into the start bit; samples each bit at mid-bit, ends mid-stop.
  task automatic sample_frame(input int sel, input logic [DW-1:0] d, input bit odd, input string tag);
    logic [FRAME_BITS-1:0] f;
    f = make_frame(d, odd);
    repeat (24) @(negedge clk);
    for (int k = 0; k < FRAME_BITS; k++) begin
      if (k > 0) repeat (BC) @(negedge clk);
      check($sformatf("%s_bit%0d", tag, k), 32'(get_tx(sel)), 32'(f[k]));
    end
  endtask

  task automatic line_check(input int sel, input logic [DW-1:0] d, input bit odd, input string tag);
    if (sel == 0) begin a_start = 1'b1; a_din = d; end
    else          begin c_start = 1'b1; c_din = d; end
    @(negedge clk);
    check({tag, "_idle_at_t"}, 32'(get_tx(sel)), 32'd1);
    a_start = 1'b0;
    c_start = 1'b0;
    @(negedge clk);
    check({tag, "_fall_at_t1"}, 32'(get_tx(sel)), 32'd0);
    sample_frame(sel, d, odd, tag);
    repeat (40) @(negedge clk);
  endtask

  // src 0: A->B, src 1: B->A. start is held 50 cycles, well inside one frame.
  task automatic xfer(input int src, input logic [DW-1:0] d, input string tag);
    if (src == 0) begin a_start = 1'b1; a_din = d; end
    else          begin b_start = 1'b1; b_din = d; end
    repeat (50) @(negedge clk);
    a_start = 1'b0;
    b_start = 1'b0;
    repeat (520) @(negedge clk);
    if (src == 0) begin
      exp_b_dout = d; exp_b_err = 1'b0;
      check({tag, "_b_dout"}, 32'(b_dout), 32'(exp_b_dout));
      check({tag, "_b_err"},  32'(b_err),  32'(exp_b_err));
    end else begin
      exp_a_dout = d; exp_a_err = 1'b0;
      check({tag, "_a_dout"}, 32'(a_dout), 32'(exp_a_dout));
      check({tag, "_a_err"},  32'(a_err),  32'(exp_a_err));
    end
  endtask

  // Drives a raw frame onto A's Rx and predicts A's result from the bits alone.
  task automatic inject(input logic [FRAME_BITS-1:0] bits, input string tag);
    int ones;
    for (int k = 0; k < FRAME_BITS; k++) begin
      inj_line = bits[k];
      repeat (BC) @(negedge clk);
    end
    inj_line = 1'b1;
    repeat (20) @(negedge clk);
    ones = 0;
    for (int i = 1; i <= DW + 1; i++) ones += int'(bits[i]);
    exp_a_dout = bits[DW:1];
    exp_a_err  = ((ones % 2) != 0) || (bits[DW+2] == 1'b0);
    check({tag, "_dout"}, 32'(a_dout), 32'(exp_a_dout));
    check({tag, "_err"},  32'(a_err),  32'(exp_a_err));
    repeat (10) @(negedge clk);
  endtask

  initial begin
    logic [DW-1:0] msg [12];
    logic [FRAME_BITS-1:0] fr;
    logic [DW-1:0] rd;
    int mode;

    msg = '{8'h48, 8'h6F, 8'h77, 8'h20, 8'h61, 8'h72, 8'h65, 8'h20, 8'h79, 8'h6F, 8'h75, 8'h3F};
    rst = 1'b1;
    a_start = 1'b0; b_start = 1'b0; c_start = 1'b0;
    a_din = '0; b_din = '0; c_din = '0;
    c_rx = 1'b1; inj_sel = 1'b0; inj_line = 1'b1;
    exp_a_dout = '0; exp_b_dout = '0; exp_a_err = 1'b0; exp_b_err = 1'b0;

    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_a_tx", 32'(a_tx), 32'd1);
    check("rst_b_tx", 32'(b_tx), 32'd1);
    check("rst_c_tx", 32'(c_tx), 32'd1);
    check("rst_a_dout", 32'(a_dout), 32'd0);
    check("rst_a_err", 32'(a_err), 32'd0);
    check("rst_b_dout", 32'(b_dout), 32'd0);
    check("rst_b_err", 32'(b_err), 32'd0);
    repeat (10) @(negedge clk);

    line_check(0, 8'h48, 1'b0, "line_even");
    exp_b_dout = 8'h48; exp_b_err = 1'b0;
    check("line_even_b_dout", 32'(b_dout), 32'(exp_b_dout));
    check("line_even_b_err", 32'(b_err), 32'(exp_b_err));
    line_check(2, 8'h48, 1'b1, "line_odd");

    xfer(0, 8'h48, "lb_48");
    xfer(0, 8'h69, "lb_69");
    xfer(0, 8'h21, "lb_21");
    for (int i = 0; i < 12; i++) xfer(1, msg[i], $sformatf("rev_%0d", i));

    for (int i = 0; i < 8; i++) begin
      rd = DW'($urandom_range(0, 255));
      xfer(int'($urandom_range(0, 1)), rd, $sformatf("rnd_lb_%0d", i));
      repeat ($urandom_range(0, 30)) @(negedge clk);
    end

    inj_sel = 1'b1;
    repeat (10) @(negedge clk);
    fr = make_frame(8'h55, 1'b0); fr[DW+1] = ~fr[DW+1];
    inject(fr, "inj_par");
    fr = make_frame(8'h55, 1'b0); fr[DW+2] = 1'b0;
    inject(fr, "inj_stop");
    inject(make_frame(8'hC3, 1'b0), "inj_clean");
    for (int i = 0; i < 6; i++) begin
      fr = make_frame(DW'($urandom_range(0, 255)), 1'b0);
      mode = int'($urandom_range(0, 3));
      if (mode[0]) fr[DW+1] = ~fr[DW+1];
      if (mode[1]) fr[DW+2] = 1'b0;
      inject(fr, $sformatf("inj_rnd_%0d", i));
    end

    inj_line = 1'b0;
    repeat (10) @(negedge clk);
    inj_line = 1'b1;
    repeat (100) @(negedge clk);
    check("glitch_dout", 32'(a_dout), 32'(exp_a_dout));
    check("glitch_err", 32'(a_err), 32'(exp_a_err));
    inj_sel = 1'b0;
    repeat (10) @(negedge clk);

    xfer(0, 8'h5A, "pre_rst");
    a_start = 1'b1; a_din = 8'h3C;
    @(negedge clk);
    a_start = 1'b0;
    repeat (200) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_a_tx", 32'(a_tx), 32'd1);
    check("rst_mid_b_dout", 32'(b_dout), 32'd0);
    check("rst_mid_b_err", 32'(b_err), 32'd0);
    check("rst_mid_a_dout", 32'(a_dout), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_a_dout = '0; exp_b_dout = '0; exp_a_err = 1'b0; exp_b_err = 1'b0;
    repeat (20) @(negedge clk);
    check("post_rst_a_tx", 32'(a_tx), 32'd1);
    xfer(0, 8'h96, "post_rst");

    a_start = 1'b1; a_din = 8'hA5;
    @(negedge clk);
    check("b2b_idle_at_t", 32'(a_tx), 32'd1);
    @(negedge clk);
    check("b2b_fall_at_t1", 32'(a_tx), 32'd0);
    for (int f = 0; f < 3; f++) begin
      sample_frame(0, 8'hA5, 1'b0, $sformatf("b2b_f%0d", f));
      if (f == 2) a_start = 1'b0;
      repeat (25) @(negedge clk);
      check($sformatf("b2b_f%0d_stop_end", f), 32'(a_tx), 32'd1);
      @(negedge clk);
      check($sformatf("b2b_f%0d_next", f), 32'(a_tx), (f < 2) ? 32'd0 : 32'd1);
    end
    repeat (20) @(negedge clk);
    exp_b_dout = 8'hA5; exp_b_err = 1'b0;
    check("b2b_b_dout", 32'(b_dout), 32'(exp_b_dout));
    check("b2b_b_err", 32'(b_err), 32'(exp_b_err));
    check("c_rx_quiet_dout", 32'(c_dout), 32'd0);
    check("c_rx_quiet_err", 32'(c_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
